// File: rtl/mem_arbiter_if.sv
// Bus bundle between the instruction fetcher / load-store buffer (master side)
// and the byte-wide RAM port arbiter (slave side), including the RAM pins.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32
);
  // Fetcher side
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic [31:0]       if_data;

  // Load/store buffer side
  logic              lsb_req;
  logic              lsb_wr;
  logic [1:0]        lsb_size;
  logic [ADDR_W-1:0] lsb_addr;
  logic [31:0]       lsb_wdata;
  logic              lsb_done;
  logic [31:0]       lsb_rdata;

  // RAM pins
  logic [7:0]        mem_din;
  logic [7:0]        mem_dout;
  logic [ADDR_W-1:0] mem_a;
  logic              mem_wr;

  modport master (
    output if_req, if_addr,
    output lsb_req, lsb_wr, lsb_size, lsb_addr, lsb_wdata,
    output mem_din,
    input  if_done, if_data,
    input  lsb_done, lsb_rdata,
    input  mem_dout, mem_a, mem_wr
  );

  modport slave (
    input  if_req, if_addr,
    input  lsb_req, lsb_wr, lsb_size, lsb_addr, lsb_wdata,
    input  mem_din,
    output if_done, if_data,
    output lsb_done, lsb_rdata,
    output mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares the single byte-wide RAM port between the instruction fetcher and the
// load/store buffer. Each access is split into per-byte RAM cycles; read bytes
// are assembled little-endian. A clear squashes pending loads/fetches and any
// in-flight read, while stores always run to completion.
module mem_arbiter #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] IO_BASE   = ADDR_W'(32'h30000),
  parameter bit                LSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  input  logic         clear,
  input  logic         io_buffer_full,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t            state, state_next;

  // Latched requests (one outstanding per requester)
  logic              if_pend, lsb_pend;
  logic [ADDR_W-1:0] if_addr_q, lsb_addr_q;
  logic              lsb_wr_q;
  logic [1:0]        lsb_size_q;
  logic [31:0]       lsb_wdata_q;

  // Transaction in flight
  logic              cur_lsb;
  logic [ADDR_W-1:0] cur_addr;
  logic [31:0]       cur_wdata;
  logic [2:0]        cur_n;
  logic [2:0]        cnt;
  logic [31:0]       asm_q;

  // Fairness: set when a simultaneous grant left someone waiting
  logic              owed, owed_lsb;

  // Registered outputs
  logic              if_done_q, lsb_done_q;
  logic [31:0]       if_data_q, lsb_rdata_q;

  // Combinational helpers
  logic              if_avail, lsb_avail, both, pick_lsb;
  logic              grant, grant_if, grant_lsb;
  logic              sel_wr;
  logic [1:0]        sel_size;
  logic [ADDR_W-1:0] sel_if_addr, sel_lsb_addr;
  logic [31:0]       sel_wdata;
  logic              wr_stall, rd_last, wr_last;
  logic [1:0]        cap_idx;
  logic [31:0]       rd_word;

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // A clear drops a pending fetch and a pending load, but never a pending store;
  // a request arriving in the same cycle always survives.
  assign if_avail  = (if_pend & ~clear) | bus.if_req;
  assign lsb_avail = (lsb_pend & ~(clear & ~lsb_wr_q)) | bus.lsb_req;
  assign both      = if_avail & lsb_avail;
  assign pick_lsb  = both ? (owed ? owed_lsb : LSB_FIRST) : lsb_avail;
  assign grant     = (state == IDLE) & (if_avail | lsb_avail);
  assign grant_lsb = grant & pick_lsb;
  assign grant_if  = grant & ~pick_lsb;

  // A request can be granted in the very cycle it arrives, before it is latched.
  assign sel_wr       = bus.lsb_req ? bus.lsb_wr    : lsb_wr_q;
  assign sel_size     = bus.lsb_req ? bus.lsb_size  : lsb_size_q;
  assign sel_lsb_addr = bus.lsb_req ? bus.lsb_addr  : lsb_addr_q;
  assign sel_wdata    = bus.lsb_req ? bus.lsb_wdata : lsb_wdata_q;
  assign sel_if_addr  = bus.if_req  ? bus.if_addr   : if_addr_q;

  assign wr_stall = (cur_addr >= IO_BASE) & io_buffer_full;
  assign rd_last  = (cnt == cur_n);
  assign wr_last  = (cnt == cur_n - 3'd1);
  assign cap_idx  = cnt[1:0] - 2'd1;

  assign bus.if_done   = if_done_q;
  assign bus.if_data   = if_data_q;
  assign bus.lsb_done  = lsb_done_q;
  assign bus.lsb_rdata = lsb_rdata_q;

  // State register; frozen while rdy is low.
  // NOTE: sequential logic uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst)      state <= IDLE;
    else if (rdy) state <= state_next;
  end

  // Next-state: grant from IDLE, leave READ on last capture or clear, leave WRITE after its last byte.
  // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant) state_next = (grant_lsb & sel_wr) ? WRITE : READ;
      READ:    if (clear | rd_last) state_next = IDLE;
      WRITE:   if (!wr_stall & wr_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // RAM pins. While frozen mid-read, the previous address is re-presented so that
  // mem_din still carries the byte still owed when rdy returns.
  always_comb begin
    bus.mem_a    = '0;
    bus.mem_dout = '0;
    bus.mem_wr   = 1'b0;
    case (state)
      READ: bus.mem_a = cur_addr + ADDR_W'(cnt) - ADDR_W'(~rdy & (cnt != 3'd0));
      WRITE: begin
        bus.mem_a    = cur_addr + ADDR_W'(cnt);
        bus.mem_dout = cur_wdata[{cnt[1:0], 3'b000} +: 8];
        bus.mem_wr   = rdy & ~wr_stall;
      end
      default: ;
    endcase
  end

  // Read word with the byte arriving this cycle merged into its lane.
  always_comb begin
    rd_word = asm_q;
    rd_word[{cap_idx, 3'b000} +: 8] = bus.mem_din;
  end

  // Request latching, transaction datapath and done/data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_pend     <= 1'b0;
      lsb_pend    <= 1'b0;
      if_addr_q   <= '0;
      lsb_addr_q  <= '0;
      lsb_wr_q    <= 1'b0;
      lsb_size_q  <= 2'd0;
      lsb_wdata_q <= '0;
      cur_lsb     <= 1'b0;
      cur_addr    <= '0;
      cur_wdata   <= '0;
      cur_n       <= 3'd0;
      cnt         <= 3'd0;
      asm_q       <= '0;
      owed        <= 1'b0;
      owed_lsb    <= 1'b0;
      if_done_q   <= 1'b0;
      lsb_done_q  <= 1'b0;
      if_data_q   <= '0;
      lsb_rdata_q <= '0;
    end else if (rdy) begin
      if_done_q  <= 1'b0;
      lsb_done_q <= 1'b0;
      if_pend    <= if_avail & ~grant_if;
      lsb_pend   <= lsb_avail & ~grant_lsb;
      if (bus.if_req) if_addr_q <= bus.if_addr;
      if (bus.lsb_req) begin
        lsb_wr_q    <= bus.lsb_wr;
        lsb_size_q  <= bus.lsb_size;
        lsb_addr_q  <= bus.lsb_addr;
        lsb_wdata_q <= bus.lsb_wdata;
      end

      case (state)
        IDLE: begin
          if (grant) begin
            cur_lsb   <= pick_lsb;
            cur_addr  <= pick_lsb ? sel_lsb_addr : sel_if_addr;
            cur_n     <= pick_lsb ? size_bytes(sel_size) : 3'd4;
            cur_wdata <= sel_wdata;
            cnt       <= 3'd0;
            asm_q     <= '0;
            owed      <= both;
            owed_lsb  <= ~pick_lsb;
          end
        end
        READ: begin
          if (!clear) begin
            if (cnt != 3'd0) asm_q <= rd_word;
            if (rd_last) begin
              if (cur_lsb) begin
                lsb_rdata_q <= rd_word;
                lsb_done_q  <= 1'b1;
              end else begin
                if_data_q <= rd_word;
                if_done_q <= 1'b1;
              end
            end else begin
              cnt <= cnt + 3'd1;
            end
          end
        end
        WRITE: begin
          if (!wr_stall) begin
            if (wr_last) lsb_done_q <= 1'b1;
            else         cnt <= cnt + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stimulus pushes expected done events and RAM
// writes into queues; a negedge monitor pops and compares them as they appear.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst, rdy, clear, io_buffer_full;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  mem_arbiter_if #(.ADDR_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .IO_BASE(32'h30000), .LSB_FIRST(1'b1)) dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .clear          (clear),
    .io_buffer_full (io_buffer_full),
    .bus            (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        chk;
    logic [31:0] data;
    int          at;
  } done_t;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  data;
    int          at;
  } wr_t;

  done_t if_q[$];
  done_t lsb_q[$];
  wr_t   wr_q[$];

  // RAM model: registered read of the address presented this cycle.
  logic [7:0] ram [0:65535];
  always @(posedge clk) begin
    bus.mem_din <= ram[bus.mem_a[15:0]];
    if (bus.mem_wr) ram[bus.mem_a[15:0]] = bus.mem_dout;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.if_req  = 1'b0;
    bus.lsb_req = 1'b0;
  endtask

  task automatic exp_done(input bit lsb, input bit chk, input logic [31:0] d, input int at);
    done_t e;
    e.chk = chk; e.data = d; e.at = at;
    if (lsb) lsb_q.push_back(e);
    else     if_q.push_back(e);
  endtask

  task automatic exp_wr(input logic [31:0] a, input logic [7:0] d, input int at);
    wr_t e;
    e.addr = a; e.data = d; e.at = at;
    wr_q.push_back(e);
  endtask

  task automatic fetch(input logic [31:0] a);
    bus.if_req  = 1'b1;
    bus.if_addr = a;
  endtask

  task automatic lsb_issue(input bit wr, input logic [1:0] size, input logic [31:0] a,
                           input logic [31:0] wd);
    bus.lsb_req   = 1'b1;
    bus.lsb_wr    = wr;
    bus.lsb_size  = size;
    bus.lsb_addr  = a;
    bus.lsb_wdata = wd;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((if_q.size() + lsb_q.size() + wr_q.size()) != 0 && n < budget) begin
      step();
      n++;
    end
    if ((if_q.size() + lsb_q.size() + wr_q.size()) != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: %0d events outstanding after %0d cycles, expected 0",
               if_q.size() + lsb_q.size() + wr_q.size(), budget);
      if_q.delete(); lsb_q.delete(); wr_q.delete();
    end
    repeat (2) step();
  endtask

  // Monitor: every RAM write and every done pulse must match the head of its queue.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (bus.mem_wr) begin
        if (wr_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_write: addr 0x%08h data 0x%02h at cycle %0d, expected none",
                   bus.mem_a, bus.mem_dout, cyc);
        end else begin
          wr_t w;
          w = wr_q.pop_front();
          check("wr_addr", bus.mem_a, w.addr);
          check("wr_data", {24'h0, bus.mem_dout}, {24'h0, w.data});
          check("wr_cycle", cyc, w.at);
        end
      end
      if (bus.if_done) begin
        if (if_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_if_done: data 0x%08h at cycle %0d, expected none", bus.if_data, cyc);
        end else begin
          done_t d;
          d = if_q.pop_front();
          check("if_done_cycle", cyc, d.at);
          if (d.chk) check("if_data", bus.if_data, d.data);
        end
      end
      if (bus.lsb_done) begin
        if (lsb_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_lsb_done: data 0x%08h at cycle %0d, expected none", bus.lsb_rdata, cyc);
        end else begin
          done_t d;
          d = lsb_q.pop_front();
          check("lsb_done_cycle", cyc, d.at);
          if (d.chk) check("lsb_rdata", bus.lsb_rdata, d.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    for (int i = 0; i < 65536; i++) ram[i] = i[7:0] ^ 8'hA5;
    ram[16'h0100] = 8'h13;
    ram[16'h0101] = 8'h05;
    ram[16'h0102] = 8'h00;
    ram[16'h0103] = 8'h00;
    ram[16'h0040] = 8'h9C;

    rst = 1'b1; rdy = 1'b1; clear = 1'b0; io_buffer_full = 1'b0;
    bus.if_addr = '0; bus.lsb_wr = 1'b0; bus.lsb_size = 2'd0;
    bus.lsb_addr = '0; bus.lsb_wdata = '0;
    idle_inputs();
    repeat (3) step();

    check("rst_if_done",   {31'h0, bus.if_done},  32'h0);
    check("rst_if_data",   bus.if_data,           32'h0);
    check("rst_lsb_done",  {31'h0, bus.lsb_done}, 32'h0);
    check("rst_lsb_rdata", bus.lsb_rdata,         32'h0);
    check("rst_mem_a",     bus.mem_a,             32'h0);
    check("rst_mem_dout",  {24'h0, bus.mem_dout}, 32'h0);
    check("rst_mem_wr",    {31'h0, bus.mem_wr},   32'h0);
    rst = 1'b0;
    step();

    // Fetch 0x100: bytes 13 05 00 00, done at cycle 6.
    c0 = cyc; fetch(32'h100); exp_done(0, 1, 32'h0000_0513, c0 + 6);
    step(); idle_inputs(); drain(30);

    // Store half 0x2000: 0x34 then 0x12, done at cycle 3.
    c0 = cyc; lsb_issue(1, 2'd1, 32'h2000, 32'hABCD_1234);
    exp_wr(32'h2000, 8'h34, c0 + 1); exp_wr(32'h2001, 8'h12, c0 + 2);
    exp_done(1, 0, 32'h0, c0 + 3);
    step(); idle_inputs(); drain(30);

    // Simultaneous fetch 0x104 and load byte 0x40: LSB first, fetch after the gap.
    c0 = cyc; fetch(32'h104); lsb_issue(0, 2'd0, 32'h40, 32'h0);
    exp_done(1, 1, 32'h0000_009C, c0 + 3);
    exp_done(0, 1, 32'hA2A3_A0A1, c0 + 9);
    step(); idle_inputs(); drain(30);

    // I/O store byte with sink full for three cycles: single write at cycle 4.
    c0 = cyc; lsb_issue(1, 2'd0, 32'h30000, 32'h0000_005A); io_buffer_full = 1'b1;
    exp_wr(32'h30000, 8'h5A, c0 + 4); exp_done(1, 0, 32'h0, c0 + 5);
    step(); idle_inputs(); repeat (3) step(); io_buffer_full = 1'b0;
    drain(30);

    // Clear after the second fetch address; the fetch issued with clear completes.
    c0 = cyc; fetch(32'h200);
    step(); idle_inputs(); step(); step();
    clear = 1'b1; fetch(32'h310); exp_done(0, 1, 32'hB6B7_B4B5, c0 + 10);
    step(); clear = 1'b0; idle_inputs(); drain(30);

    // rdy low for five cycles mid-fetch: same data, five cycles later.
    c0 = cyc; fetch(32'h420); exp_done(0, 1, 32'h8687_8485, c0 + 11);
    step(); idle_inputs(); step(); step();
    rdy = 1'b0; repeat (5) step(); rdy = 1'b1;
    drain(30);

    // Word store with rdy low for two cycles after the first byte.
    c0 = cyc; lsb_issue(1, 2'd2, 32'h500, 32'h1122_3344);
    exp_wr(32'h500, 8'h44, c0 + 1); exp_wr(32'h501, 8'h33, c0 + 4);
    exp_wr(32'h502, 8'h22, c0 + 5); exp_wr(32'h503, 8'h11, c0 + 6);
    exp_done(1, 0, 32'h0, c0 + 7);
    step(); idle_inputs(); step(); rdy = 1'b0; step(); step(); rdy = 1'b1;
    drain(30);

    // Unaligned half load from 0x501 reads back stored bytes, zero-extended.
    c0 = cyc; lsb_issue(0, 2'd1, 32'h501, 32'h0); exp_done(1, 1, 32'h0000_2233, c0 + 4);
    step(); idle_inputs(); drain(30);

    // Word load 0x2000: two stored bytes plus two untouched RAM bytes.
    c0 = cyc; lsb_issue(0, 2'd3, 32'h2000, 32'h0); exp_done(1, 1, 32'hA6A7_1234, c0 + 6);
    step(); idle_inputs(); drain(30);

    // Clear during an in-flight store: the store still completes.
    c0 = cyc; lsb_issue(1, 2'd1, 32'h600, 32'h0000_BEEF);
    exp_wr(32'h600, 8'hEF, c0 + 1); exp_wr(32'h601, 8'hBE, c0 + 2);
    exp_done(1, 0, 32'h0, c0 + 3);
    step(); idle_inputs(); clear = 1'b1; step(); clear = 1'b0;
    drain(30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
